// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation-select encodings and main-decoder classes.
// Used by alu_control and the ALU datapath.
package alu_pkg;

    typedef enum logic [2:0] {
        CTR_AND = 3'b000,
        CTR_ADD = 3'b001,
        CTR_SUB = 3'b010,
        CTR_XOR = 3'b011,
        CTR_NOR = 3'b100,
        CTR_OR  = 3'b101,
        CTR_SLT = 3'b110,
        CTR_SLL = 3'b111
    } alu_ctr_e;

    typedef enum logic [1:0] {
        OP_LDST = 2'b00,
        OP_BR   = 2'b01,
        OP_RTYP = 2'b10,
        OP_SLTI = 2'b11
    } alu_op_e;

    function automatic alu_ctr_e alu_decode(input logic [1:0] op, input logic [2:0] fn);
        alu_ctr_e ctr;
        ctr = CTR_ADD;
        unique case (alu_op_e'(op))
            OP_LDST: ctr = CTR_ADD;
            OP_BR:   ctr = CTR_SUB;
            OP_RTYP: ctr = alu_ctr_e'(fn);
            OP_SLTI: ctr = CTR_SLT;
        endcase
        return ctr;
    endfunction

    function automatic logic alu_uses_sub(input alu_ctr_e ctr);
        return (ctr == CTR_SUB) || (ctr == CTR_SLT);
    endfunction

endpackage

// File: rtl/alu_control.sv
// ALU control decoder: maps main-decoder class and R-type function field
// to an ALU operation select, optionally registered.
module alu_control
    import alu_pkg::*;
#(
    parameter bit REGISTERED = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] ALUop,
    input  logic [2:0] func,
    output logic [2:0] ALUctr,
    output logic       sub_en,
    output logic       valid
);

    alu_ctr_e w_ctr;
    logic     w_sub;

    always_comb begin
        w_ctr = alu_decode(ALUop, func);
        w_sub = alu_uses_sub(w_ctr);
    end

    generate
        if (REGISTERED) begin : g_reg
            logic [2:0] r_ctr;
            logic       r_sub;
            logic       r_valid;

            // Reset wins over en, so a decode sampled during reset is dropped.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_ctr   <= 3'b000;
                    r_sub   <= 1'b0;
                    r_valid <= 1'b0;
                end else if (en) begin
                    r_ctr   <= w_ctr;
                    r_sub   <= w_sub;
                    r_valid <= 1'b1;
                end
            end

            assign ALUctr = r_ctr;
            assign sub_en = r_sub;
            assign valid  = r_valid;
        end else begin : g_comb
            logic w_unused;
            assign w_unused = &{1'b0, clk, reset, en};

            assign ALUctr = w_ctr;
            assign sub_en = w_sub;
            assign valid  = 1'b1;
        end
    endgenerate

endmodule

// File: tb/tb_alu_control.sv
// Scoreboard bench for alu_control: registered and combinational builds.
module tb_alu_control;

    typedef struct {
        logic [2:0] ctr;
        logic       sub;
        logic       vld;
        int         due;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] ALUop;
    logic [2:0] func;
    logic [2:0] ALUctr;
    logic       sub_en;
    logic       valid;

    logic [1:0] c_op;
    logic [2:0] c_func;
    logic [2:0] c_ctr;
    logic       c_sub;
    logic       c_valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t q[$];
    exp_t qc[$];

    alu_control #(.REGISTERED(1'b1)) dut_reg (
        .clk(clk), .reset(reset), .en(en),
        .ALUop(ALUop), .func(func),
        .ALUctr(ALUctr), .sub_en(sub_en), .valid(valid)
    );

    alu_control #(.REGISTERED(1'b0)) dut_comb (
        .clk(clk), .reset(reset), .en(en),
        .ALUop(c_op), .func(c_func),
        .ALUctr(c_ctr), .sub_en(c_sub), .valid(c_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Registered monitor: checks entries whose result is due this cycle.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            total++;
            if (ALUctr !== e.ctr || sub_en !== e.sub || valid !== e.vld) begin
                bad++;
                $display("FAIL %s: got ctr=%b sub=%b vld=%b want ctr=%b sub=%b vld=%b",
                         e.nm, ALUctr, sub_en, valid, e.ctr, e.sub, e.vld);
            end
        end
    end

    // Combinational monitor.
    initial begin
        exp_t e;
        forever begin
            wait (qc.size() > 0);
            #1;
            e = qc.pop_front();
            total++;
            if (c_ctr !== e.ctr || c_sub !== e.sub || c_valid !== e.vld) begin
                bad++;
                $display("FAIL %s: got ctr=%b sub=%b vld=%b want ctr=%b sub=%b vld=%b",
                         e.nm, c_ctr, c_sub, c_valid, e.ctr, e.sub, e.vld);
            end
        end
    end

    task automatic drv(input logic rst, input logic e, input logic [1:0] op,
                       input logic [2:0] f, input logic [2:0] ec,
                       input logic es, input logic ev, input string nm);
        exp_t x;
        @(negedge clk);
        reset = rst;
        en    = e;
        ALUop = op;
        func  = f;
        x.ctr = ec; x.sub = es; x.vld = ev; x.due = cyc + 1; x.nm = nm;
        q.push_back(x);
    endtask

    task automatic cdrv(input logic [2:0] f, input logic [2:0] ec,
                        input logic es, input string nm);
        exp_t x;
        c_op   = 2'b10;
        c_func = f;
        x.ctr = ec; x.sub = es; x.vld = 1'b1; x.due = 0; x.nm = nm;
        qc.push_back(x);
        #10;
    endtask

    logic [7:0] sub_tab;

    initial begin
        reset  = 1'b1;
        en     = 1'b0;
        ALUop  = 2'b00;
        func   = 3'b000;
        c_op   = 2'b00;
        c_func = 3'b000;
        sub_tab = 8'b0100_0100;

        drv(1, 1, 2'b10, 3'b101, 3'b000, 0, 0, "reset1");
        drv(1, 1, 2'b10, 3'b101, 3'b000, 0, 0, "reset2");

        drv(0, 0, 2'b00, 3'b000, 3'b000, 0, 0, "idle_after_reset");

        drv(0, 1, 2'b00, 3'b111, 3'b001, 0, 1, "ldst");
        drv(0, 1, 2'b01, 3'b111, 3'b010, 1, 1, "branch");
        drv(0, 1, 2'b11, 3'b111, 3'b110, 1, 1, "slti");

        for (int i = 0; i < 8; i++)
            drv(0, 1, 2'b10, 3'(i), 3'(i), sub_tab[i], 1, $sformatf("rtype_%0d", i));

        drv(0, 1, 2'b10, 3'b011, 3'b011, 0, 1, "hold_load");
        for (int i = 0; i < 3; i++)
            drv(0, 0, 2'b01, 3'b000, 3'b011, 0, 1, $sformatf("hold_%0d", i));

        drv(1, 1, 2'b01, 3'b000, 3'b000, 0, 0, "rst_prio");
        drv(0, 1, 2'b01, 3'b000, 3'b010, 1, 1, "after_rst");

        drv(0, 1, 2'b10, 3'b100, 3'b100, 0, 1, "pre_mid_rst");
        drv(1, 1, 2'b00, 3'b101, 3'b000, 0, 0, "mid_rst");
        drv(0, 1, 2'b11, 3'b000, 3'b110, 1, 1, "post_mid_rst");
        drv(0, 0, 2'b00, 3'b000, 3'b110, 1, 1, "post_mid_hold");

        for (int i = 0; i < 20 && q.size() > 0; i++)
            @(posedge clk);
        #3;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL reg_drain: got pending=%0d want 0", q.size());
        end

        for (int i = 0; i < 8; i++)
            cdrv(3'(i), 3'(i), sub_tab[i], $sformatf("comb_rtype_%0d", i));
        c_op = 2'b00;
        qc.push_back('{3'b001, 1'b0, 1'b1, 0, "comb_ldst"});
        #10;
        c_op = 2'b01;
        qc.push_back('{3'b010, 1'b1, 1'b1, 0, "comb_branch"});
        #10;
        c_op = 2'b11;
        qc.push_back('{3'b110, 1'b1, 1'b1, 0, "comb_slti"});
        #10;
        if (qc.size() > 0) begin
            bad++;
            $display("FAIL comb_drain: got pending=%0d want 0", qc.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
